bus_led_ctrl: RTL and testbench
===============================

BUS_LED_CTRL -- requirements
Module: bus_led_ctrl

Interface
REQ-001 SHALL have parameter BUS_ADDR, default 32'h0300_0000, base byte address of the register block.
REQ-002 SHALL have parameter CHANNELS, default 8, LED channel count, legal range 1..16.
REQ-003 SHALL have parameter TICK_DIV, default 12000, clk cycles per blink tick (1 ms at 12 MHz), legal range 2..2^20.
REQ-004 SHALL have ports: clk  in  1  clock (already decided).
REQ-005 SHALL have: reset_l_in  in  1  reset, asynchronous, active-low (already decided).
REQ-006 SHALL have: addr  in  32  byte address; wdata  in  32  write data; be  in  4  byte enables.
REQ-007 SHALL have: rd_req  in  1  read strobe; wr_req  in  1  write strobe; each is a one-cycle pulse.
REQ-008 SHALL have: rd_data  out  32  read data; rd_ack  out  1  read done; wr_ack  out  1  write done.
REQ-009 SHALL have: leds  out  CHANNELS  LED drive, 1 = lit.

Function
REQ-010 SHALL map channel n control register CTRL[n] at BUS_ADDR+4*n: [1:0] mode (0 off, 1 on, 2 blink, 3 pwm); [15:8] duty; [31:16] half-period in ticks; other bits read 0.
REQ-011 SHALL map a read-only STATUS at BUS_ADDR+4*CHANNELS: [CHANNELS-1:0] = current leds value, [31] = tick heartbeat phase (toggles each 512 ticks).
REQ-012 SHALL ack a decoded write exactly 1 cycle after wr_req; only bytes with be set are updated; writes to STATUS are acked and ignored.
REQ-013 SHALL ack a decoded read 1 cycle after rd_req with rd_data valid in the same cycle as rd_ack.
REQ-014 SHALL drive rd_data = 0 whenever rd_ack is low, so outputs OR-combine onto the SoC bus.
REQ-015 SHALL give no ack and rd_data 0 for addresses outside BUS_ADDR..BUS_ADDR+4*CHANNELS and for addresses with addr[1:0] != 0.
REQ-016 SHALL ignore a cycle where rd_req and wr_req are both high: no ack, no update.
REQ-017 SHALL generate a tick pulse once every TICK_DIV clk cycles from a free-running prescaler.
REQ-018 SHALL, per channel in blink mode, decrement a 16-bit counter on each tick and, on reaching 0, reload the half-period and toggle the phase; half-period 0 is treated as 1.
REQ-019 SHALL, on any write to CTRL[n] (any be), reload channel n's blink counter and set its phase to lit, effective the cycle after wr_ack.
REQ-020 SHALL drive leds[n] as: mode 0 -> 0; mode 1 -> 1; mode 2 -> phase; mode 3 -> PWM output per REQ-027.
REQ-021 SHALL register leds (one clk cycle from internal state to pin); a mode change appears on leds at most 2 cycles after wr_ack.

Reset
REQ-022 SHALL synchronise reset_l_in through 2 flops: assertion is immediate (asynchronous), deassertion synchronous to clk.
REQ-023 SHALL, while reset is asserted, hold leds = 0, rd_data = 0, rd_ack = 0, wr_ack = 0, all CTRL = 0, prescaler, blink and PWM counters = 0, phases = lit.
REQ-024 SHALL abandon any in-flight bus access on reset with no ack issued, including mid-cycle assertion.
REQ-025 SHALL ignore rd_req/wr_req until the synchronised reset has deasserted.

Configuration
REQ-026 SHALL compile PWM support only when macro LED_PWM_EN is defined.
REQ-027 SHALL, with LED_PWM_EN, run one shared free-running 8-bit PWM counter incremented every clk and drive a mode-3 channel high while counter < duty (duty 0 -> always off, duty 255 -> lit 255 of 256 cycles).
REQ-028 SHALL, without LED_PWM_EN, omit the PWM counter, treat mode 3 as mode 1, and read CTRL[n][15:8] as 0.

Verification
REQ-029 SHALL cover: reset release, write CTRL[0]=32'h0000_0001 be=4'hF -> wr_ack 1 cycle later, leds[0]=1 within 2 cycles; read CTRL[0] -> 32'h0000_0001.
REQ-030 SHALL cover: TICK_DIV=4, CTRL[1]=32'h0003_0002 -> leds[1] lit 12 cycles then dark 12 cycles, repeating.
REQ-031 SHALL cover: LED_PWM_EN defined, CTRL[2]=32'h0000_4003 -> leds[2] high exactly 64 of every 256 cycles; undefined -> leds[2] constantly 1, readback 32'h0000_0003.
REQ-032 SHALL cover: read BUS_ADDR+4*CHANNELS+4 and write BUS_ADDR+2 -> no rd_ack/wr_ack, rd_data 0, no register changes.
REQ-033 SHALL cover: write CTRL[3]=32'hFFFF_FFFF with be=4'h1 after CTRL[3]=0 -> reads 32'h0000_0003; rd_req and wr_req together -> no ack.
REQ-034 SHALL cover: reset_l_in asserted the cycle after wr_req -> no wr_ack, leds=0 immediately, all CTRL read 0 after release.

Source files
------------

// File: rtl/bus_led_ctrl.sv
// LED controller: CTRL[n] at BUS_ADDR+4n, read-only STATUS after the last channel; bus acks one cycle after the strobe.
// Optional macro LED_PWM_EN adds a shared 8-bit PWM counter for mode 3; without it mode 3 behaves as always-on.
module bus_led_ctrl #(
    parameter logic [31:0] BUS_ADDR = 32'h0300_0000,
    parameter int          CHANNELS = 8,
    parameter int          TICK_DIV = 12000
) (
    input  logic                clk,
    input  logic                reset_l_in,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    input  logic [3:0]          be,
    input  logic                rd_req,
    input  logic                wr_req,
    output logic [31:0]         rd_data,
    output logic                rd_ack,
    output logic                wr_ack,
    output logic [CHANNELS-1:0] leds
);
    localparam int PW = $clog2(TICK_DIV);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [PW-1:0]       r_pre;
    logic                w_tick;
    logic [9:0]          r_hb_cnt;
    logic [1:0]          r_mode  [CHANNELS];
    logic [15:0]         r_hp    [CHANNELS];
    logic [15:0]         r_cnt   [CHANNELS];
    logic                r_phase [CHANNELS];
    logic [7:0]          w_duty  [CHANNELS];
    logic [CHANNELS-1:0] w_pwm_out;
    logic [CHANNELS-1:0] w_led_nxt;
    logic [31:0]         w_off;
    logic [29:0]         w_word;
    logic                w_hit;
    logic                w_is_status;
    logic                w_wr_go;
    logic                w_rd_go;
    logic [31:0]         w_rd_val;
    logic [15:0]         w_hp_new;
    logic                w_unused_ok;
    logic                r_rd_ack;
    logic                r_wr_ack;
    logic [31:0]         r_rd_data;
    logic [CHANNELS-1:0] r_leds;

    function automatic logic [15:0] hp_eff(input logic [15:0] hp);
        return (hp == 16'd0) ? 16'd1 : hp;
    endfunction

    // Reset asserts asynchronously, releases two clk edges later.
    always_ff @(posedge clk or negedge reset_l_in) begin
        if (!reset_l_in) r_rst_sync <= 2'b00;
        else             r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pre    <= '0;
            r_hb_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    // Addresses below the base wrap to huge offsets and fall out of range.
    assign w_off       = addr - BUS_ADDR;
    assign w_word      = w_off[31:2];
    assign w_hit       = (w_off[1:0] == 2'b00) && (w_word <= 30'(CHANNELS));
    assign w_is_status = (w_word == 30'(CHANNELS));
    assign w_wr_go     = wr_req && !rd_req && w_hit;
    assign w_rd_go     = rd_req && !wr_req && w_hit;

    always_comb begin
        w_rd_val = '0;
        if (w_is_status) begin
            w_rd_val[CHANNELS-1:0] = r_leds;
            w_rd_val[31]           = r_hb_cnt[9];
        end else begin
            for (int n = 0; n < CHANNELS; n++)
                if (w_word == 30'(n)) w_rd_val = {r_hp[n], w_duty[n], 6'd0, r_mode[n]};
        end
    end

    // Half-period as it will stand after this write, used to reload the blink counter.
    assign w_hp_new = {be[3] ? wdata[31:24] : w_rd_val[31:24],
                       be[2] ? wdata[23:16] : w_rd_val[23:16]};

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_mode[n]  <= 2'd0;
                r_hp[n]    <= 16'd0;
                r_cnt[n]   <= 16'd0;
                r_phase[n] <= 1'b1;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (w_wr_go && w_word == 30'(n)) begin
                    if (be[0]) r_mode[n]       <= wdata[1:0];
                    if (be[2]) r_hp[n][7:0]    <= wdata[23:16];
                    if (be[3]) r_hp[n][15:8]   <= wdata[31:24];
                    r_cnt[n]   <= hp_eff(w_hp_new);
                    r_phase[n] <= 1'b1;
                end else if (w_tick && r_mode[n] == 2'd2) begin
                    if (r_cnt[n] <= 16'd1) begin
                        r_cnt[n]   <= hp_eff(r_hp[n]);
                        r_phase[n] <= !r_phase[n];
                    end else begin
                        r_cnt[n] <= r_cnt[n] - 16'd1;
                    end
                end
            end
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] r_pwm;
    logic [7:0] r_duty [CHANNELS];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pwm <= 8'd0;
            for (int n = 0; n < CHANNELS; n++) r_duty[n] <= 8'd0;
        end else begin
            r_pwm <= r_pwm + 8'd1;
            for (int n = 0; n < CHANNELS; n++)
                if (w_wr_go && be[1] && w_word == 30'(n)) r_duty[n] <= wdata[15:8];
        end
    end

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            w_duty[n]    = r_duty[n];
            w_pwm_out[n] = (r_pwm < r_duty[n]);
        end
    end
`else
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            w_duty[n]    = 8'd0;
            w_pwm_out[n] = 1'b1;
        end
    end
`endif

    always_comb begin
        w_led_nxt = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            case (r_mode[n])
                2'd0:    w_led_nxt[n] = 1'b0;
                2'd1:    w_led_nxt[n] = 1'b1;
                2'd2:    w_led_nxt[n] = r_phase[n];
                default: w_led_nxt[n] = w_pwm_out[n];
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_leds    <= '0;
            r_rd_ack  <= 1'b0;
            r_wr_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_leds    <= w_led_nxt;
            r_rd_ack  <= w_rd_go;
            r_wr_ack  <= w_wr_go;
            r_rd_data <= w_rd_go ? w_rd_val : 32'd0;
        end
    end

    assign leds        = r_leds;
    assign rd_ack      = r_rd_ack;
    assign wr_ack      = r_wr_ack;
    assign rd_data     = r_rd_data;
    assign w_unused_ok = &{1'b0, wdata[7:2], wdata[15:8], be[1]};
endmodule

// File: tb/tb_bus_led_ctrl.sv
// Bench for bus_led_ctrl: vector table, blink/PWM timing, randomized accesses against a register model, reset corners.
module tb_bus_led_ctrl;
    localparam logic [31:0] BUS = 32'h0300_0000;
    localparam int          CH  = 8;
`ifdef LED_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif
    localparam logic [31:0] MASK = PWM ? 32'hFFFF_FF03 : 32'hFFFF_0003;

    logic          clk;
    logic          reset_l_in;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          rd_req;
    logic          wr_req;
    logic [31:0]   rd_data;
    logic          rd_ack;
    logic          wr_ack;
    logic [CH-1:0] leds;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic        ack;
        logic [31:0] rd;
    } vec_t;

    vec_t        vt [16];
    logic [31:0] model [CH];

    bus_led_ctrl #(.BUS_ADDR(BUS), .CHANNELS(CH), .TICK_DIV(4)) dut (
        .clk(clk), .reset_l_in(reset_l_in), .addr(addr), .wdata(wdata), .be(be),
        .rd_req(rd_req), .wr_req(wr_req), .rd_data(rd_data), .rd_ack(rd_ack),
        .wr_ack(wr_ack), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (b[k]) r[8*k +: 8] = d[8*k +: 8];
        return r & MASK;
    endfunction

    // Called just after a negedge; returns the ack/data seen one cycle later.
    task automatic bus_op(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                          output logic ack, output logic [31:0] rd);
        addr = a; wdata = d; be = b; wr_req = wr; rd_req = !wr;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        ack = wr ? wr_ack : rd_ack;
        rd  = rd_data;
    endtask

    task automatic both_req(input string name, input logic [31:0] a);
        addr = a; wdata = $urandom; be = 4'hF; wr_req = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        check({name, "_rd_ack"}, {31'd0, rd_ack}, 32'd0);
        check({name, "_wr_ack"}, {31'd0, wr_ack}, 32'd0);
        check({name, "_rdata"}, rd_data, 32'd0);
    endtask

    initial begin
        logic        ack;
        logic [31:0] rd;
        logic        seen;
        logic        prev;
        logic        started;
        int          run_len;
        int          runs;
        int          hi;
        int          kind;
        int          ch;
        int          sel;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [1:0]  mode;

        clk = 1'b0; reset_l_in = 1'b0; addr = '0; wdata = '0; be = '0;
        rd_req = 1'b0; wr_req = 1'b0; n_tests = 0; n_fail = 0;
        for (int i = 0; i < CH; i++) model[i] = '0;

        vt[0]  = '{1'b1, BUS,           32'h0000_0001, 4'hF, 1'b1, 32'h0};
        vt[1]  = '{1'b0, BUS,           32'h0,         4'hF, 1'b1, 32'h0000_0001};
        vt[2]  = '{1'b1, BUS + 32'd2,   32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vt[3]  = '{1'b0, BUS + 32'h24,  32'h0,         4'hF, 1'b0, 32'h0};
        vt[4]  = '{1'b0, BUS,           32'h0,         4'hF, 1'b1, 32'h0000_0001};
        vt[5]  = '{1'b1, BUS + 32'h0C,  32'h0,         4'hF, 1'b1, 32'h0};
        vt[6]  = '{1'b1, BUS + 32'h0C,  32'hFFFF_FFFF, 4'h1, 1'b1, 32'h0};
        vt[7]  = '{1'b0, BUS + 32'h0C,  32'h0,         4'hF, 1'b1, 32'h0000_0003};
        vt[8]  = '{1'b1, BUS + 32'h08,  32'h0000_4003, 4'hF, 1'b1, 32'h0};
        vt[9]  = '{1'b0, BUS + 32'h08,  32'h0,         4'hF, 1'b1, PWM ? 32'h0000_4003 : 32'h0000_0003};
        vt[10] = '{1'b1, BUS + 32'h20,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        vt[11] = '{1'b0, BUS + 32'h14,  32'h0,         4'hF, 1'b1, 32'h0};
        vt[12] = '{1'b1, BUS + 32'h10,  32'h1234_5679, 4'hC, 1'b1, 32'h0};
        vt[13] = '{1'b0, BUS + 32'h10,  32'h0,         4'hF, 1'b1, 32'h1234_0000};
        vt[14] = '{1'b1, BUS + 32'h10,  32'hAABB_CCDD, 4'h3, 1'b1, 32'h0};
        vt[15] = '{1'b0, BUS + 32'h10,  32'h0,         4'hF, 1'b1, PWM ? 32'h1234_CC01 : 32'h1234_0001};

        // Reset state, and strobes ignored while held in reset
        repeat (3) @(negedge clk);
        check("rst_leds", {24'd0, leds}, 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        check("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
        check("rst_wr_ack", {31'd0, wr_ack}, 32'd0);
        bus_op(1'b1, BUS, 32'h1, 4'hF, ack, rd);
        check("rst_wr_ignored", {31'd0, ack}, 32'd0);
        reset_l_in = 1'b1;
        repeat (4) @(negedge clk);
        bus_op(1'b0, BUS, 32'h0, 4'hF, ack, rd);
        check("post_rst_rd_ack", {31'd0, ack}, 32'd1);
        check("post_rst_ctrl0", rd, 32'd0);
        bus_op(1'b0, BUS + 32'h20, 32'h0, 4'hF, ack, rd);
        check("post_rst_status", rd, 32'd0);

        // Turn on channel 0
        bus_op(1'b1, BUS, 32'h0000_0001, 4'hF, ack, rd);
        check("on_wr_ack", {31'd0, ack}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (leds[0]) seen = 1'b1;
        end
        check("on_led0", {31'd0, seen}, 32'd1);
        bus_op(1'b0, BUS, 32'h0, 4'hF, ack, rd);
        check("on_readback", rd, 32'h0000_0001);
        bus_op(1'b0, BUS + 32'h20, 32'h0, 4'hF, ack, rd);
        check("on_status", rd, 32'h0000_0001);

        for (int i = 0; i < 16; i++) begin
            bus_op(vt[i].wr, vt[i].a, vt[i].d, vt[i].b, ack, rd);
            check($sformatf("vec%0d_ack", i), {31'd0, ack}, {31'd0, vt[i].ack});
            check($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d_idle_rdata", i), rd_data, 32'd0);
        end
        model[0] = 32'h0000_0001;
        model[2] = 32'h0000_4003 & MASK;
        model[3] = 32'h0000_0003;
        model[4] = vt[15].rd;

        both_req("both", BUS + 32'h0C);
        bus_op(1'b0, BUS + 32'h0C, 32'h0, 4'hF, ack, rd);
        check("both_no_update", rd, 32'h0000_0003);

        // Blink: 3-tick half period at 4 clk per tick -> 12-cycle runs
        bus_op(1'b1, BUS + 32'h04, 32'h0003_0002, 4'hF, ack, rd);
        model[1] = 32'h0003_0002;
        @(negedge clk);
        check("blink_start_lit", {31'd0, leds[1]}, 32'd1);
        prev = leds[1]; run_len = 0; runs = 0; started = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (leds[1] !== prev) begin
                if (started) begin
                    check($sformatf("blink_run%0d", runs), run_len, 32'd12);
                    runs++;
                end
                started = 1'b1;
                run_len = 1;
                prev    = leds[1];
            end else begin
                run_len++;
            end
        end
        check("blink_run_count", {31'd0, runs >= 10}, 32'd1);

        // Channel 2 in mode 3 with duty 0x40
        for (int w = 0; w < 2; w++) begin
            hi = 0;
            for (int c = 0; c < 256; c++) begin
                @(negedge clk);
                if (leds[2]) hi++;
            end
            check($sformatf("pwm_window%0d", w), hi, PWM ? 32'd64 : 32'd256);
        end

        // Randomized accesses on channels 4..7 against the register model
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 3);
            ch   = $urandom_range(4, 7);
            a    = BUS + 32'(4 * ch);
            case (kind)
                0: begin
                    d = $urandom;
                    b = 4'($urandom_range(0, 15));
                    bus_op(1'b1, a, d, b, ack, rd);
                    check("rand_wr_ack", {31'd0, ack}, 32'd1);
                    model[ch] = merge(model[ch], d, b);
                    repeat (2) @(negedge clk);
                    mode = model[ch][1:0];
                    if (mode == 2'd0 || mode == 2'd1 || (mode == 2'd3 && !PWM))
                        check($sformatf("rand_led%0d", ch), {31'd0, leds[ch]}, {31'd0, mode != 2'd0});
                end
                1: begin
                    bus_op(1'b0, a, 32'h0, 4'hF, ack, rd);
                    check("rand_rd_ack", {31'd0, ack}, 32'd1);
                    check($sformatf("rand_rd%0d", ch), rd, model[ch]);
                end
                2: begin
                    sel = $urandom_range(0, 2);
                    case (sel)
                        0:       a = BUS + 32'(4 * CH + 4 * $urandom_range(1, 64));
                        1:       a = BUS + 32'(4 * $urandom_range(0, CH) + $urandom_range(1, 3));
                        default: a = BUS - 32'(4 * $urandom_range(1, 64));
                    endcase
                    bus_op(1'($urandom_range(0, 1)), a, $urandom, 4'hF, ack, rd);
                    check("rand_bad_ack", {31'd0, ack}, 32'd0);
                    check("rand_bad_rdata", rd, 32'd0);
                end
                default: both_req("rand_both", a);
            endcase
        end
        for (int i = 0; i < CH; i++) begin
            bus_op(1'b0, BUS + 32'(4 * i), 32'h0, 4'hF, ack, rd);
            check($sformatf("final_rd%0d", i), rd, model[i]);
        end

        // Reset arriving on the edge that would raise wr_ack
        bus_op(1'b1, BUS, 32'h0000_0001, 4'hF, ack, rd);
        repeat (2) @(negedge clk);
        check("pre_reset_led0", {31'd0, leds[0]}, 32'd1);
        addr = BUS + 32'h18; wdata = 32'h0000_0001; be = 4'hF; wr_req = 1'b1;
        @(posedge clk);
        reset_l_in = 1'b0;
        #1;
        wr_req = 1'b0;
        check("midrst_wr_ack", {31'd0, wr_ack}, 32'd0);
        check("midrst_leds", {24'd0, leds}, 32'd0);
        @(negedge clk);
        check("midrst_wr_ack_late", {31'd0, wr_ack}, 32'd0);
        repeat (2) @(negedge clk);
        reset_l_in = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            bus_op(1'b0, BUS + 32'(4 * i), 32'h0, 4'hF, ack, rd);
            check($sformatf("midrst_ack%0d", i), {31'd0, ack}, 32'd1);
            check($sformatf("midrst_ctrl%0d", i), rd, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
